// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the run_ctrl sequencer.
package run_ctrl_pkg;

  localparam int unsigned START_CYCLES_DEF = 2;
  localparam int unsigned CNT_W_DEF        = 16;
  localparam logic [15:0] TIMEOUT_DEF      = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MEMRST = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_MEMRST = 3'd1;
  localparam state_t ST_START  = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that stops at a limit instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count < limit)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Program-run sequencer: memory reset pulse, core start hold, bounded run with
// halt/abort/timeout exit, and a one-cycle completion pulse.
//
// state  | meaning
// IDLE   | waiting for run_req
// MEMRST | dm_reset pulse to the core, one cycle
// START  | start held high for START_CYCLES cycles
// RUN    | core executing, cycle_ct counting
// DONE   | run_done pulse, result valid
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned      START_CYCLES = START_CYCLES_DEF,
  parameter int unsigned      CNT_W        = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT      = CNT_W'(TIMEOUT_DEF)
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             run_req,
  input  logic             abort,
  input  logic             halt,
  output logic             dm_reset,
  output logic             start,
  output logic             busy,
  output logic             run_done,
  output logic             run_ok,
  output logic [CNT_W-1:0] cycle_ct
);

  localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] start_cnt;
  logic       start_last;
  logic       at_limit;
  logic       ct_clr;
  logic       ct_en;

  assign start_last = (start_cnt == START_LAST);
  assign at_limit   = (cycle_ct == TIMEOUT);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (run_req) state_nxt = ST_MEMRST;
      ST_MEMRST: state_nxt = ST_START;
      ST_START:  if (start_last) state_nxt = ST_RUN;
      ST_RUN:    if (halt || abort || at_limit) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Cleared while in MEMRST so it reads zero on the first START cycle.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      start_cnt <= 4'd0;
    end else if (state == ST_MEMRST) begin
      start_cnt <= 4'd0;
    end else if ((state == ST_START) && !start_last) begin
      start_cnt <= start_cnt + 4'd1;
    end
  end

  // Result flag is captured on the RUN exit edge; abort/timeout leave it at 0.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      run_ok <= 1'b0;
    end else if (state == ST_MEMRST) begin
      run_ok <= 1'b0;
    end else if ((state == ST_RUN) && halt) begin
      run_ok <= 1'b1;
    end
  end

  assign ct_clr = (state == ST_MEMRST);
  assign ct_en  = (state == ST_RUN) && !halt && !abort;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_ct (
    .CLK     (CLK),
    .reset_n (reset_n),
    .clr     (ct_clr),
    .en      (ct_en),
    .limit   (TIMEOUT),
    .count   (cycle_ct)
  );

  assign dm_reset = (state == ST_MEMRST);
  assign start    = (state == ST_START);
  assign busy     = (state != ST_IDLE);
  assign run_done = (state == ST_DONE);

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with START_CYCLES=2, TIMEOUT=8.
module tb_run_ctrl;

  logic        CLK;
  logic        reset_n;
  logic        run_req;
  logic        abort;
  logic        halt;
  logic        dm_reset;
  logic        start;
  logic        busy;
  logic        run_done;
  logic        run_ok;
  logic [15:0] cycle_ct;

  int total;
  int bad;

  // Flag group order: dm_reset, start, busy, run_done, run_ok
  localparam logic [4:0] F_IDLE0 = 5'b00000;
  localparam logic [4:0] F_IDLE1 = 5'b00001;
  localparam logic [4:0] F_MEM0  = 5'b10100;
  localparam logic [4:0] F_MEM1  = 5'b10101;
  localparam logic [4:0] F_ST    = 5'b01100;
  localparam logic [4:0] F_RUN   = 5'b00100;
  localparam logic [4:0] F_DOK   = 5'b00111;
  localparam logic [4:0] F_DBAD  = 5'b00110;

  logic [20:0] obs;
  logic [20:0] exp;

  assign obs = {dm_reset, start, busy, run_done, run_ok, cycle_ct};

  run_ctrl #(
    .START_CYCLES (2),
    .CNT_W        (16),
    .TIMEOUT      (16'd8)
  ) dut (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .run_req  (run_req),
    .abort    (abort),
    .halt     (halt),
    .dm_reset (dm_reset),
    .start    (start),
    .busy     (busy),
    .run_done (run_done),
    .run_ok   (run_ok),
    .cycle_ct (cycle_ct)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    #2;
    exp = {F_IDLE0, 16'd0}; total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_state: got %h want %h", obs, exp); end
    tick;
    reset_n = 1'b1;
    halt = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      exp = {F_IDLE0, 16'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL idle_ignores_halt_abort: got %h want %h", obs, exp); end
    end
    halt = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_normal;
    run_req = 1'b1;
    tick;
    run_req = 1'b0;
    exp = {F_MEM0, 16'd0}; total++;
    if (obs !== exp) begin bad++; $display("FAIL normal_memrst: got %h want %h", obs, exp); end
    for (int i = 0; i < 2; i++) begin
      tick;
      exp = {F_ST, 16'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL normal_start: got %h want %h", obs, exp); end
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      exp = {F_RUN, 16'(i)}; total++;
      if (obs !== exp) begin bad++; $display("FAIL normal_run: got %h want %h", obs, exp); end
    end
    halt = 1'b1;
    tick;
    halt = 1'b0;
    exp = {F_DOK, 16'd4}; total++;
    if (obs !== exp) begin bad++; $display("FAIL normal_done: got %h want %h", obs, exp); end
    tick;
    exp = {F_IDLE1, 16'd4}; total++;
    if (obs !== exp) begin bad++; $display("FAIL normal_idle_hold: got %h want %h", obs, exp); end
  endtask

  task automatic test_timeout;
    run_req = 1'b1;
    tick;
    run_req = 1'b0;
    exp = {F_MEM1, 16'd4}; total++;
    if (obs !== exp) begin bad++; $display("FAIL timeout_memrst_hold: got %h want %h", obs, exp); end
    for (int i = 0; i < 2; i++) begin
      tick;
      exp = {F_ST, 16'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL timeout_start_clear: got %h want %h", obs, exp); end
    end
    for (int i = 0; i < 9; i++) begin
      tick;
      exp = {F_RUN, 16'(i)}; total++;
      if (obs !== exp) begin bad++; $display("FAIL timeout_run: got %h want %h", obs, exp); end
    end
    tick;
    exp = {F_DBAD, 16'd8}; total++;
    if (obs !== exp) begin bad++; $display("FAIL timeout_done: got %h want %h", obs, exp); end
    for (int i = 0; i < 3; i++) begin
      tick;
      exp = {F_IDLE0, 16'd8}; total++;
      if (obs !== exp) begin bad++; $display("FAIL timeout_idle_sat: got %h want %h", obs, exp); end
    end
  endtask

  task automatic test_exit_priority;
    run_req = 1'b1;
    tick;
    run_req = 1'b0;
    exp = {F_MEM0, 16'd8}; total++;
    if (obs !== exp) begin bad++; $display("FAIL both_memrst: got %h want %h", obs, exp); end
    tick;
    tick;
    tick;
    tick;
    exp = {F_RUN, 16'd1}; total++;
    if (obs !== exp) begin bad++; $display("FAIL both_run2: got %h want %h", obs, exp); end
    halt = 1'b1;
    abort = 1'b1;
    tick;
    halt = 1'b0;
    abort = 1'b0;
    exp = {F_DOK, 16'd1}; total++;
    if (obs !== exp) begin bad++; $display("FAIL both_done_halt_wins: got %h want %h", obs, exp); end
    tick;
    exp = {F_IDLE1, 16'd1}; total++;
    if (obs !== exp) begin bad++; $display("FAIL both_idle: got %h want %h", obs, exp); end

    run_req = 1'b1;
    tick;
    run_req = 1'b0;
    exp = {F_MEM1, 16'd1}; total++;
    if (obs !== exp) begin bad++; $display("FAIL abort_memrst: got %h want %h", obs, exp); end
    for (int i = 0; i < 5; i++) tick;
    exp = {F_RUN, 16'd2}; total++;
    if (obs !== exp) begin bad++; $display("FAIL abort_run3: got %h want %h", obs, exp); end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    exp = {F_DBAD, 16'd2}; total++;
    if (obs !== exp) begin bad++; $display("FAIL abort_done: got %h want %h", obs, exp); end
    tick;
    exp = {F_IDLE0, 16'd2}; total++;
    if (obs !== exp) begin bad++; $display("FAIL abort_idle: got %h want %h", obs, exp); end
  endtask

  task automatic test_ignored;
    run_req = 1'b1;
    tick;
    halt = 1'b1;
    abort = 1'b1;
    exp = {F_MEM0, 16'd2}; total++;
    if (obs !== exp) begin bad++; $display("FAIL ign_memrst: got %h want %h", obs, exp); end
    tick;
    exp = {F_ST, 16'd0}; total++;
    if (obs !== exp) begin bad++; $display("FAIL ign_start1: got %h want %h", obs, exp); end
    tick;
    exp = {F_ST, 16'd0}; total++;
    if (obs !== exp) begin bad++; $display("FAIL ign_start2: got %h want %h", obs, exp); end
    run_req = 1'b0;
    halt = 1'b0;
    abort = 1'b0;
    tick;
    exp = {F_RUN, 16'd0}; total++;
    if (obs !== exp) begin bad++; $display("FAIL ign_run1: got %h want %h", obs, exp); end
    tick;
    exp = {F_RUN, 16'd1}; total++;
    if (obs !== exp) begin bad++; $display("FAIL ign_run2: got %h want %h", obs, exp); end
    halt = 1'b1;
    tick;
    run_req = 1'b1;
    abort = 1'b1;
    exp = {F_DOK, 16'd1}; total++;
    if (obs !== exp) begin bad++; $display("FAIL ign_done: got %h want %h", obs, exp); end
    tick;
    run_req = 1'b0;
    halt = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = {F_IDLE1, 16'd1}; total++;
      if (obs !== exp) begin bad++; $display("FAIL ign_no_extra_run: got %h want %h", obs, exp); end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    run_req = 1'b1;
    tick;
    run_req = 1'b0;
    exp = {F_MEM1, 16'd1}; total++;
    if (obs !== exp) begin bad++; $display("FAIL mid_memrst: got %h want %h", obs, exp); end
    for (int i = 0; i < 6; i++) tick;
    exp = {F_RUN, 16'd3}; total++;
    if (obs !== exp) begin bad++; $display("FAIL mid_run_ct3: got %h want %h", obs, exp); end
    #1;
    reset_n = 1'b0;
    #1;
    exp = {F_IDLE0, 16'd0}; total++;
    if (obs !== exp) begin bad++; $display("FAIL mid_async_clear: got %h want %h", obs, exp); end
    for (int i = 0; i < 2; i++) begin
      tick;
      exp = {F_IDLE0, 16'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL mid_held_reset: got %h want %h", obs, exp); end
    end
    reset_n = 1'b1;
    tick;
    exp = {F_IDLE0, 16'd0}; total++;
    if (obs !== exp) begin bad++; $display("FAIL mid_idle_after_release: got %h want %h", obs, exp); end
    run_req = 1'b1;
    tick;
    run_req = 1'b0;
    exp = {F_MEM0, 16'd0}; total++;
    if (obs !== exp) begin bad++; $display("FAIL mid_rerun_memrst: got %h want %h", obs, exp); end
    for (int i = 0; i < 3; i++) tick;
    halt = 1'b1;
    tick;
    halt = 1'b0;
    exp = {F_DOK, 16'd0}; total++;
    if (obs !== exp) begin bad++; $display("FAIL mid_rerun_done: got %h want %h", obs, exp); end
    tick;
    exp = {F_IDLE1, 16'd0}; total++;
    if (obs !== exp) begin bad++; $display("FAIL mid_rerun_idle: got %h want %h", obs, exp); end
  endtask

  task automatic test_back_to_back;
    run_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick;
      exp = {F_MEM1, 16'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL b2b_memrst: got %h want %h", obs, exp); end
      for (int i = 0; i < 2; i++) begin
        tick;
        exp = {F_ST, 16'd0}; total++;
        if (obs !== exp) begin bad++; $display("FAIL b2b_start: got %h want %h", obs, exp); end
      end
      tick;
      exp = {F_RUN, 16'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL b2b_run1: got %h want %h", obs, exp); end
      halt = 1'b1;
      tick;
      halt = 1'b0;
      exp = {F_DOK, 16'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL b2b_done: got %h want %h", obs, exp); end
      if (r == 1) run_req = 1'b0;
      tick;
      exp = {F_IDLE1, 16'd0}; total++;
      if (obs !== exp) begin bad++; $display("FAIL b2b_idle_gap: got %h want %h", obs, exp); end
    end
    tick;
    exp = {F_IDLE1, 16'd0}; total++;
    if (obs !== exp) begin bad++; $display("FAIL b2b_no_third_run: got %h want %h", obs, exp); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    run_req = 1'b0;
    abort = 1'b0;
    halt = 1'b0;
    test_reset;
    test_normal;
    test_timeout;
    test_exit_priority;
    test_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
